// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt.sv - W-bit period counter with wrap and high-phase compare
module gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         wrap,
    output logic         high_next
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] half;

    // cnt never exceeds div-1 while running, so cnt+1 always fits in W bits
    assign cnt_inc   = cnt + W'(1);
    assign half      = (div >> 1) + {{(W-1){1'b0}}, div[0]};
    assign wrap      = (cnt_inc == div);
    assign high_next = (cnt_inc < half);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv - programmable glitch-free clock divider with staged ratio
module gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DIV,
    input  logic         LOAD,
    output logic         CLKO,
    output logic         CLKO_N,
    output logic         TICK,
    output logic         BUSY
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] DEF_RAW = W'(DEF_DIV);

    function automatic logic [W-1:0] eff_div(input logic [W-1:0] v);
        return (v == W'(1)) ? W'(2) : v;
    endfunction

    state_t       state;
    logic [W-1:0] act;
    logic [W-1:0] stg;
    logic         busy;
    logic         fresh;
    logic         clko_q;
    logic         clko_n_q;
    logic         tick_q;
    logic         wrap;
    logic         high_next;
    logic         boundary;
    logic         stg_runs;

    // fresh marks the first edge after reset, which opens a period without waiting for a wrap
    assign boundary = (state == RUN) && (fresh || wrap);
    assign stg_runs = (eff_div(stg) >= W'(2));

    gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(.W(W)) u_cnt (
        .clk       (CLK),
        .rst       (RST),
        .clr       ((state != RUN) || boundary),
        .div       (eff_div(act)),
        .wrap      (wrap),
        .high_next (high_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= (eff_div(DEF_RAW) >= W'(2)) ? RUN : STOP;
            act      <= DEF_RAW;
            stg      <= '0;
            busy     <= 1'b0;
            fresh    <= 1'b1;
            clko_q   <= 1'b0;
            clko_n_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            fresh  <= 1'b0;
            tick_q <= 1'b0;
            if (LOAD) begin
                stg  <= DIV;
                busy <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (boundary) begin
                        if (busy && !stg_runs) begin
                            act      <= stg;
                            busy     <= LOAD;
                            state    <= STOP;
                            clko_q   <= 1'b0;
                            clko_n_q <= 1'b1;
                        end else begin
                            if (busy) begin
                                act  <= stg;
                                busy <= LOAD;
                            end
                            clko_q   <= 1'b1;
                            clko_n_q <= 1'b0;
                            tick_q   <= 1'b1;
                        end
                    end else begin
                        clko_q   <= high_next;
                        clko_n_q <= ~high_next;
                    end
                end
                default: begin
                    clko_q   <= 1'b0;
                    clko_n_q <= 1'b1;
                    if (busy) begin
                        act  <= stg;
                        busy <= LOAD;
                        if (stg_runs) begin
                            state    <= RUN;
                            clko_q   <= 1'b1;
                            clko_n_q <= 1'b0;
                            tick_q   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign CLKO   = clko_q;
    assign CLKO_N = clko_n_q;
    assign TICK   = tick_q;
    assign BUSY   = busy;

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.md
Name: gf180mcu_osu_sc_gp12t3v3__clkdiv_prog

Overview:
Programmable, glitch-free clock divider for the 12T 3.3V library. It is the generating end of the clock-distribution path: it produces a registered divided clock and its registered complement, which then feed the clkinv/clkbuf trees. The division ratio can be changed at runtime through a LOAD/BUSY handshake. A new ratio takes effect only at a period boundary, so no runt pulses are produced.

Parameters:
W, 8, width of the ratio field and of the internal period counter
DEF_DIV, 4, ratio loaded at reset; 0 = stopped, 1 is treated as 2, legal range 0..2^W-1

Ports:
CLK  input  1  source clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
DIV  input  W  requested ratio, sampled when LOAD=1
LOAD  input  1  one-cycle request to stage DIV
CLKO  output  1  divided clock, registered
CLKO_N  output  1  registered complement of CLKO; always equal to ~CLKO, never a combinational inverter
TICK  output  1  one-cycle pulse in the first CLK cycle of each CLKO high phase
BUSY  output  1  a staged ratio is waiting to be applied

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Effective ratio: D = (value==1) ? 2 : value. H = ceil(D/2) high cycles, D-H low cycles.
- Reset (RST=1 at an edge):
  - CLKO=0, CLKO_N=1, TICK=0, BUSY=0.
  - Active ratio = DEF_DIV; staged ratio is discarded.
  - Period counter cnt=0.
  - State = RUN if effective DEF_DIV>=2, otherwise STOP.
  - Reset mid-period or mid-handshake aborts immediately; no completion pulse.
- State RUN:
  - First edge with RST=0 starts a period: CLKO=1, TICK=1, cnt=0.
  - Each subsequent edge: cnt advances. cnt==D-1 wraps to 0, and that edge is the period boundary.
  - CLKO=1 while cnt<H, else 0. TICK=1 only on edges where cnt becomes 0.
  - Total period is exactly D CLK cycles.
- State STOP:
  - CLKO=0, CLKO_N=1, TICK=0, cnt held at 0.
- LOAD handling:
  - At an edge with LOAD=1, DIV is captured into the staged register and BUSY=1 from the next cycle.
  - LOAD while BUSY=1 overwrites the staged value. Still only one application occurs; last write wins.
- Application in RUN:
  - Applied at the next period boundary edge. That edge starts the new period with the new D: CLKO=1, TICK=1 if the new value >=2.
  - BUSY=0 at the same edge.
  - If the staged value is 0: at the boundary, CLKO=0, no TICK, state goes to STOP.
- Application in STOP:
  - Applied at the edge following capture; BUSY is high for exactly one cycle.
  - If the staged value >=2: state goes to RUN and the period starts at that edge.
  - If the staged value is 0: stays in STOP.
- LOAD coinciding with the boundary edge:
  - The previously staged value, if any, is applied at that edge.
  - The new DIV becomes staged, BUSY=1, and it is applied at the following boundary.
  - If nothing was staged, the current D continues and the new value waits one full period.
- No output ever holds a level for fewer than min(H, D-H) CLK cycles in RUN. A ratio change never truncates a period.
- Counter width W; D up to 2^W-1. No arithmetic overflow, because cnt<=D-1.

Decomposition:
- No shared package needed.
- Local constants: state encoding (STOP, RUN) and the effective-ratio function.
- One natural sub-module: gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt, the W-bit period counter with wrap/boundary output and H compare.
- The top level holds the staging register, FSM and output flops.

Test Plan:
- Reset release, DEF_DIV=4 -> CLKO pattern 1,1,0,0 repeating from the first edge after RST=0. TICK every 4th cycle. CLKO_N = ~CLKO in every cycle. BUSY=0.
- Mid-period LOAD, DIV=5, while running at 4 -> BUSY=1 until the next boundary. The current 4-cycle period completes intact, then the pattern becomes 1,1,1,0,0. BUSY=0 at the boundary.
- LOAD DIV=3 then LOAD DIV=6 in the same period -> one application only, at the next boundary. Pattern becomes 1,1,1,0,0,0; 3 is never seen.
- LOAD DIV=0 -> at the boundary CLKO goes to 0 and stays 0, TICK=0. Then LOAD DIV=2 -> BUSY for one cycle, CLKO=1 and TICK=1 on the next edge, pattern 1,0 repeating.
- DIV=1 -> behaves exactly as DIV=2. LOAD asserted on the boundary edge -> applied one period later, per the coincidence rule.
- RST asserted during the CLKO high phase with BUSY=1 -> next cycle CLKO=0, CLKO_N=1, BUSY=0, TICK=0. The staged value is lost, and the DEF_DIV pattern restarts after release.
